// File: rtl/rom_fetch_unit_pkg.sv
// Shared accelerator package: fetch FSM state type, beat-count helper and
// the default widths shared with the decoder and memory blocks.
package accel_pkg;

   localparam int unsigned DEF_ROM_ADDR_W = 8;
   localparam int unsigned DEF_ROM_DATA_W = 8;
   localparam int unsigned DEF_INSTR_W    = 16;
   localparam int unsigned DEF_FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PUSH  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   function automatic int unsigned beats(input int unsigned instr_w,
                                         input int unsigned data_w);
      return instr_w / data_w;
   endfunction

endpackage

// File: rtl/rom_fetch_unit_if.sv
// Bus bundle between the fetch unit, the program ROM and the decoder.
// stall_cycles exists only when FETCH_STALL_CNT_EN is defined.
interface rom_fetch_unit_if
   import accel_pkg::*;
#(
   parameter int unsigned ROM_ADDR_W = DEF_ROM_ADDR_W,
   parameter int unsigned ROM_DATA_W = DEF_ROM_DATA_W,
   parameter int unsigned INSTR_W    = DEF_INSTR_W,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic                  go;
   logic [ROM_ADDR_W-1:0] start_addr;
   logic [ROM_ADDR_W-1:0] end_addr;
   logic [ROM_ADDR_W-1:0] rom_address;
   logic [ROM_DATA_W-1:0] data_from_rom;
   logic                  start_for_decoder;
   logic [INSTR_W-1:0]    data_for_decoder;
   logic                  ready_from_decoder;
   logic                  busy;
   logic                  done;
   logic [LVL_W-1:0]      fifo_level;
`ifdef FETCH_STALL_CNT_EN
   logic [15:0]           stall_cycles;
`endif

   // master: controller/ROM/decoder side; slave: the fetch unit
   modport master (
      output go, start_addr, end_addr, data_from_rom, ready_from_decoder,
      input  rom_address, start_for_decoder, data_for_decoder, busy, done,
`ifdef FETCH_STALL_CNT_EN
      input  stall_cycles,
`endif
      input  fifo_level
   );

   modport slave (
      input  go, start_addr, end_addr, data_from_rom, ready_from_decoder,
      output rom_address, start_for_decoder, data_for_decoder, busy, done,
`ifdef FETCH_STALL_CNT_EN
      output stall_cycles,
`endif
      output fifo_level
   );

endinterface

// File: rtl/rom_fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count; head output reads 0
// while empty so the decoder bus is quiet after reset.
module fetch_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_din,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [LW-1:0]    r_level;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_level == LW'(DEPTH));
   assign o_empty = (r_level == '0);
   assign w_pop   = i_pop && !o_empty;
   assign w_push  = i_push && (!o_full || w_pop);
   assign o_dout  = o_empty ? '0 : r_mem[r_rd];
   assign o_level = r_level;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_push && !w_pop)      r_level <= r_level + 1'b1;
         else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      end
   end

endmodule

// File: rtl/rom_fetch_unit.sv
// ROM-to-decoder fetch unit: packs ROM words into instructions and queues
// them for the decoder. Optional FETCH_STALL_CNT_EN adds stall_cycles.
module rom_fetch_unit
   import accel_pkg::*;
#(
   parameter int unsigned ROM_ADDR_W = DEF_ROM_ADDR_W,
   parameter int unsigned ROM_DATA_W = DEF_ROM_DATA_W,
   parameter int unsigned INSTR_W    = DEF_INSTR_W,
   parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic           clk,
   input  logic           reset,
   rom_fetch_unit_if.slave bus
);
   localparam int unsigned BEATS     = beats(INSTR_W, ROM_DATA_W);
   localparam logic [2:0]  LAST_BEAT = 3'(BEATS - 1);

   fetch_state_e          r_state;
   fetch_state_e          w_state_nxt;
   logic [ROM_ADDR_W-1:0] r_addr;
   logic [ROM_ADDR_W-1:0] r_end;
   logic [2:0]            r_beat;
   logic [INSTR_W-1:0]    r_word;
   logic [INSTR_W-1:0]    w_word_nxt;
   logic                  r_last;
   logic                  w_at_end;
   logic                  w_final;
   logic                  w_push;
   logic                  w_done;
   logic                  w_full;
   logic                  w_empty;

   assign w_at_end = (r_addr == r_end);
   assign w_final  = (r_beat == LAST_BEAT);

   // Beat 0 starts from zero so an early end leaves upper beats zero-filled.
   always_comb begin
      w_word_nxt = (r_beat == 3'd0) ? '0 : r_word;
      for (int unsigned b = 0; b < BEATS; b++) begin
         if (r_beat == 3'(b)) w_word_nxt[b*ROM_DATA_W +: ROM_DATA_W] = bus.data_from_rom;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE:  if (bus.go) w_state_nxt = FETCH;
         FETCH: if (w_final || w_at_end) w_state_nxt = PUSH;
         PUSH: begin
            if (!w_full) begin
               w_push      = 1'b1;
               w_state_nxt = r_last ? DRAIN : FETCH;
            end
         end
         DRAIN: begin
            if (w_empty) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_end   <= '0;
         r_beat  <= '0;
         r_word  <= '0;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            IDLE: begin
               if (bus.go) begin
                  r_addr <= bus.start_addr;
                  r_end  <= bus.end_addr;
                  r_beat <= '0;
                  r_last <= 1'b0;
               end
            end
            FETCH: begin
               r_word <= w_word_nxt;
               r_addr <= r_addr + 1'b1;
               r_last <= w_at_end;
               r_beat <= (w_final || w_at_end) ? 3'd0 : r_beat + 3'd1;
            end
            default: ;
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (INSTR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (r_word),
      .i_pop   (bus.ready_from_decoder),
      .o_dout  (bus.data_for_decoder),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (bus.fifo_level)
   );

   assign bus.rom_address       = r_addr;
   assign bus.start_for_decoder = !w_empty;
   assign bus.busy              = (r_state != IDLE);
   assign bus.done              = w_done;

`ifdef FETCH_STALL_CNT_EN
   logic [15:0] r_stall_cycles;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= '0;
      end else if (r_state == IDLE && bus.go) begin
         r_stall_cycles <= '0;
      end else if (r_state == PUSH && w_full && r_stall_cycles != '1) begin
         r_stall_cycles <= r_stall_cycles + 16'd1;
      end
   end

   assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: ROM model, decoder sink and a
// scoreboard of expected instructions built from the ROM contents.
module tb_rom_fetch_unit;
   logic clk;
   logic reset;
   logic [7:0]  rom [256];
   logic [15:0] exp_q [$];
   int checks;
   int errors;

   rom_fetch_unit_if bus ();

   rom_fetch_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.data_from_rom = rom[bus.rom_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference packing: little-endian beats, stop after end_addr, wrap at 8 bits.
   task automatic load_expected(input logic [7:0] s, input logic [7:0] e);
      logic [7:0]  a;
      logic [15:0] w;
      bit          fin;
      a   = s;
      fin = 1'b0;
      while (!fin) begin
         w = '0;
         for (int b = 0; b < 2; b++) begin
            if (!fin) begin
               w[b*8 +: 8] = rom[a];
               if (a == e) fin = 1'b1;
               a = a + 8'd1;
            end
         end
         exp_q.push_back(w);
      end
   endtask

   task automatic start_prog(input logic [7:0] s, input logic [7:0] e);
      @(negedge clk);
      bus.start_addr = s;
      bus.end_addr   = e;
      bus.go         = 1'b1;
      load_expected(s, e);
      @(negedge clk);
      bus.go = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.rom_address !== 8'h00) begin errors++; $display("FAIL reset_addr got %h exp 00", bus.rom_address); end
      checks++; if (bus.start_for_decoder !== 1'b0) begin errors++; $display("FAIL reset_start got %b exp 0", bus.start_for_decoder); end
      checks++; if (bus.data_for_decoder !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", bus.data_for_decoder); end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done); end
      checks++; if (bus.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int first_cyc;
      int done_cnt;
      int pops;
      logic [15:0] exp;
      for (int i = 0; i < 256; i++) rom[i] = 8'(i);
      bus.ready_from_decoder = 1'b1;
      start_prog(8'h00, 8'h07);
      checks++; if (exp_q.size() != 4 || exp_q[0] !== 16'h0100 || exp_q[3] !== 16'h0706) begin errors++; $display("FAIL basic_model size %0d exp 4", exp_q.size()); end
      first_cyc = -1; done_cnt = 0; pops = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.start_for_decoder && first_cyc < 0) first_cyc = c;
         if (bus.start_for_decoder && bus.ready_from_decoder) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL basic_extra got %h exp none", bus.data_for_decoder); end
            else begin
               exp = exp_q.pop_front(); pops++;
               if (bus.data_for_decoder !== exp) begin errors++; $display("FAIL basic_data got %h exp %h", bus.data_for_decoder, exp); end
            end
         end
         if (bus.done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      checks++; if (first_cyc != 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", first_cyc); end
      checks++; if (pops != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", pops); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", bus.busy); end
      exp_q.delete();
   endtask

   task automatic test_stall();
      logic [7:0]  frozen;
      logic [15:0] exp;
      int pops;
      int done_cnt;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
      bus.ready_from_decoder = 1'b0;
      start_prog(8'h00, 8'd19);
      repeat (30) @(negedge clk);
      checks++; if (bus.fifo_level !== 3'd4) begin errors++; $display("FAIL stall_level got %0d exp 4", bus.fifo_level); end
      frozen = bus.rom_address;
      repeat (5) @(negedge clk);
      checks++; if (bus.rom_address !== frozen) begin errors++; $display("FAIL stall_addr got %h exp %h", bus.rom_address, frozen); end
      checks++; if (bus.start_for_decoder !== 1'b1 || bus.data_for_decoder !== exp_q[0]) begin errors++; $display("FAIL stall_head got %h exp %h", bus.data_for_decoder, exp_q[0]); end
      bus.ready_from_decoder = 1'b1;
      pops = 0; done_cnt = 0;
      for (int c = 0; c < 80; c++) begin
         if (bus.start_for_decoder && bus.ready_from_decoder) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL stall_extra got %h exp none", bus.data_for_decoder); end
            else begin
               exp = exp_q.pop_front(); pops++;
               if (bus.data_for_decoder !== exp) begin errors++; $display("FAIL stall_data got %h exp %h", bus.data_for_decoder, exp); end
            end
         end
         if (bus.done === 1'b1) done_cnt++;
         @(negedge clk);
      end
      checks++; if (pops != 10) begin errors++; $display("FAIL stall_count got %0d exp 10", pops); end
      checks++; if (done_cnt != 1 || bus.busy !== 1'b0) begin errors++; $display("FAIL stall_done got %0d/%b exp 1/0", done_cnt, bus.busy); end
      exp_q.delete();
   endtask

   task automatic test_boundaries();
      logic [7:0]  s_tab [3] = '{8'h10, 8'hFE, 8'h30};
      logic [7:0]  e_tab [3] = '{8'h12, 8'h01, 8'h30};
      int          n_tab [3] = '{2, 2, 1};
      logic [15:0] exp;
      int pops;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(1, 255));
      bus.ready_from_decoder = 1'b1;
      for (int t = 0; t < 3; t++) begin
         start_prog(s_tab[t], e_tab[t]);
         checks++; if (exp_q.size() != n_tab[t]) begin errors++; $display("FAIL bound_model%0d got %0d exp %0d", t, exp_q.size(), n_tab[t]); end
         pops = 0;
         for (int c = 0; c < 30; c++) begin
            if (bus.start_for_decoder && bus.ready_from_decoder) begin
               checks++;
               if (exp_q.size() == 0) begin errors++; $display("FAIL bound_extra%0d got %h exp none", t, bus.data_for_decoder); end
               else begin
                  exp = exp_q.pop_front(); pops++;
                  if (bus.data_for_decoder !== exp) begin errors++; $display("FAIL bound_data%0d got %h exp %h", t, bus.data_for_decoder, exp); end
                  if (t != 1 && pops == n_tab[t] && bus.data_for_decoder[15:8] !== 8'h00) begin
                     errors++; $display("FAIL bound_zfill%0d got %h exp 00", t, bus.data_for_decoder[15:8]);
                  end
               end
            end
            @(negedge clk);
         end
         checks++; if (pops != n_tab[t] || bus.busy !== 1'b0) begin errors++; $display("FAIL bound_count%0d got %0d exp %0d", t, pops, n_tab[t]); end
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      bit          hit;
      logic [15:0] exp;
      int pops;
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
      bus.ready_from_decoder = 1'b0;
      start_prog(8'h00, 8'd19);
      hit = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (!hit && bus.fifo_level === 3'd2) hit = 1'b1;
         if (!hit) @(negedge clk);
      end
      checks++; if (!hit) begin errors++; $display("FAIL rst_mid_fill got %0d exp 2", bus.fifo_level); end
      reset = 1'b1;
      #1;
      checks++; if (bus.start_for_decoder !== 1'b0 || bus.data_for_decoder !== 16'h0 || bus.fifo_level !== 3'd0) begin
         errors++; $display("FAIL rst_mid_fifo got %b/%h/%0d exp 0/0000/0", bus.start_for_decoder, bus.data_for_decoder, bus.fifo_level);
      end
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rom_address !== 8'h00) begin
         errors++; $display("FAIL rst_mid_ctrl got %b/%b/%h exp 0/0/00", bus.busy, bus.done, bus.rom_address);
      end
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      bus.ready_from_decoder = 1'b1;
      start_prog(8'h40, 8'h43);
      pops = 0;
      for (int c = 0; c < 30; c++) begin
         if (bus.start_for_decoder && bus.ready_from_decoder) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL restart_extra got %h exp none", bus.data_for_decoder); end
            else begin
               exp = exp_q.pop_front(); pops++;
               if (bus.data_for_decoder !== exp) begin errors++; $display("FAIL restart_data got %h exp %h", bus.data_for_decoder, exp); end
            end
         end
         @(negedge clk);
      end
      checks++; if (pops != 2 || bus.busy !== 1'b0) begin errors++; $display("FAIL restart_count got %0d exp 2", pops); end
      exp_q.delete();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.go = 1'b0;
      bus.start_addr = '0;
      bus.end_addr = '0;
      bus.ready_from_decoder = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = '0;
      test_reset();
      test_basic();
      test_stall();
      test_boundaries();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
